// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared memory geometry and arbiter state for mem_port_arbiter.
package mem_arb_pkg;
    localparam int DEPTH      = 256;
    localparam int ARB_ADDR_W = $clog2(DEPTH);
    localparam int ARB_DATA_W = 32;
    typedef enum logic {ARB, LOCKED} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority encoder; the first set req bit at or after ptr
// (wrapping) wins, returned as a one-hot grant plus its index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    always_comb begin
        int i;
        gnt = '0;
        idx = '0;
        i   = 0;
        // Walk from the far end so the candidate nearest ptr is assigned last.
        for (int k = N - 1; k >= 0; k--) begin
            i = (int'(ptr) + k) % N;
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one single-port memory among NUM_REQ
// requesters with a 1-cycle read response. Define ARB_LOCK_EN for req_lock.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d, pick_idx, gidx;
    logic [NUM_REQ-1:0] pick_gnt, rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rdata_q;
    logic               xfer;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req(req_valid),
        .ptr(rr_ptr_q),
        .gnt(pick_gnt),
        .idx(pick_idx)
    );

`ifdef ARB_LOCK_EN
    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          held;

    always_comb begin
        held      = (state_q == LOCKED) && req_lock[owner_q];
        gidx      = held ? owner_q : pick_idx;
        req_ready = held ? (req_valid & (NUM_REQ'(1) << owner_q)) : pick_gnt;
        state_d   = (held || (|req_ready && req_lock[gidx])) ? LOCKED : ARB;
        owner_d   = (!held && |req_ready && req_lock[gidx]) ? gidx : owner_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ARB;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`else
    always_comb begin
        gidx      = pick_idx;
        req_ready = pick_gnt;
    end
`endif

    always_comb begin
        xfer        = |(req_valid & req_ready);
        mem_en      = xfer;
        mem_we      = req_we[gidx];
        mem_addr    = req_addr[gidx*ADDR_W +: ADDR_W];
        mem_wdata   = req_wdata[gidx*DATA_W +: DATA_W];
        rr_ptr_d    = !xfer ? rr_ptr_q : (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
        rsp_valid_d = (xfer && !mem_we) ? req_ready : '0;
        rsp_valid   = rsp_valid_q;
        // Memory output is already registered; the hold register only keeps it afterwards.
        rsp_rdata   = |rsp_valid_q ? mem_rdata : rdata_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rsp_rdata;
        end
    end
endmodule
